// File: rtl/add_chain_pipe_pkg.sv
// Shared sizing helpers for the add-chain pipeline: result width and occupancy
// counter width derived from the operand width and adder count.
package add_chain_pipe_pkg;

    function automatic int sum_width(input int width, input int stages);
        return width + $clog2(stages + 1);
    endfunction

    function automatic int occ_width(input int stages);
        return $clog2(stages + 1) + 1;
    endfunction

endpackage

// File: rtl/add_chain_pipe_if.sv
// Operand-in / sum-out valid-ready bundle for add_chain_pipe.
interface add_chain_pipe_if import add_chain_pipe_pkg::*; #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
);
    localparam int SW = sum_width(WIDTH, STAGES);

    logic                         in_valid;
    logic                         in_ready;
    logic [STAGES:0][WIDTH-1:0]   ops_i;
    logic                         out_valid;
    logic                         out_ready;
    logic [SW-1:0]                sum_o;

    modport master (
        output in_valid, ops_i, out_ready,
        input  in_ready, out_valid, sum_o
    );

    modport slave (
        input  in_valid, ops_i, out_ready,
        output in_ready, out_valid, sum_o
    );
endinterface

// File: rtl/add_chain_pipe_stage.sv
// One pipeline slot: holds a partial sum plus the operands still to be added,
// adds one operand on load, and advances when empty or when downstream takes.
module add_chain_pipe_stage import add_chain_pipe_pkg::*; #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4,
    parameter int SW     = sum_width(WIDTH, STAGES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       up_valid_i,
    input  logic [SW-1:0]              up_partial_i,
    input  logic [STAGES:0][WIDTH-1:0] up_ops_i,
    input  logic [WIDTH-1:0]           add_op_i,
    input  logic                       down_take_i,
    output logic                       take_o,
    output logic                       valid_o,
    output logic [SW-1:0]              partial_o,
    output logic [STAGES:0][WIDTH-1:0] ops_o
);

    typedef struct packed {
        logic                       valid;
        logic [SW-1:0]              partial;
        logic [STAGES:0][WIDTH-1:0] ops;
    } slot_t;

    slot_t slot_q;
    slot_t slot_d;
    logic  take_s;

    // Next-slot computation; flush drops validity but leaves data untouched.
    always_comb begin
        take_s = ~slot_q.valid | down_take_i;
        slot_d = slot_q;
        if (flush_i) begin
            slot_d.valid = 1'b0;
        end else if (take_s) begin
            slot_d.valid = up_valid_i;
        end else begin
            slot_d.valid = slot_q.valid;
        end
        if (take_s && up_valid_i) begin
            slot_d.partial = up_partial_i + {{(SW-WIDTH){1'b0}}, add_op_i};
            slot_d.ops     = up_ops_i;
        end else begin
            slot_d.partial = slot_q.partial;
            slot_d.ops     = slot_q.ops;
        end
    end

    // Slot register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign take_o    = take_s;
    assign valid_o   = slot_q.valid;
    assign partial_o = slot_q.partial;
    assign ops_o     = slot_q.ops;

endmodule

// File: rtl/add_chain_pipe.sv
// Multi-operand adder chain: STAGES registered adder slots (FORWARD=0) or one
// combinational sum feeding a single slot (FORWARD=1), with flush and occupancy.
module add_chain_pipe import add_chain_pipe_pkg::*; #(
    parameter int WIDTH   = 8,
    parameter int STAGES  = 4,
    parameter int FORWARD = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    add_chain_pipe_if.slave               bus,
    output logic [occ_width(STAGES)-1:0]  occupancy
);

    localparam int SW = sum_width(WIDTH, STAGES);
    localparam int OW = occ_width(STAGES);

    typedef logic [STAGES:0][WIDTH-1:0] ops_t;

    logic          in_valid_s;
    logic          first_take_s;
    logic          last_valid_s;
    logic [SW-1:0] last_sum_s;
    logic          accept_s;
    logic          out_hs_s;
    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;

    assign in_valid_s = bus.in_valid & ~flush_i;

    generate
        if (FORWARD == 0) begin : g_chain
            logic          valid_s   [0:STAGES];
            logic [SW-1:0] partial_s [0:STAGES];
            ops_t          ops_s     [0:STAGES];
            logic          take_s    [1:STAGES];
            logic          down_s    [1:STAGES];

            // Virtual slot 0 is the incoming operand set with ops[0] as the base.
            assign valid_s[0]   = in_valid_s;
            assign partial_s[0] = {{(SW-WIDTH){1'b0}}, bus.ops_i[0]};
            assign ops_s[0]     = bus.ops_i;

            for (genvar s = 1; s <= STAGES; s++) begin : g_stage
                if (s == STAGES) begin : g_last
                    assign down_s[s] = bus.out_ready;
                end else begin : g_mid
                    assign down_s[s] = take_s[s+1];
                end

                add_chain_pipe_stage #(
                    .WIDTH  (WIDTH),
                    .STAGES (STAGES),
                    .SW     (SW)
                ) u_stage (
                    .clk          (clk),
                    .rst_n        (rst_n),
                    .flush_i      (flush_i),
                    .up_valid_i   (valid_s[s-1]),
                    .up_partial_i (partial_s[s-1]),
                    .up_ops_i     (ops_s[s-1]),
                    .add_op_i     (ops_s[s-1][s]),
                    .down_take_i  (down_s[s]),
                    .take_o       (take_s[s]),
                    .valid_o      (valid_s[s]),
                    .partial_o    (partial_s[s]),
                    .ops_o        (ops_s[s])
                );
            end

            assign first_take_s = take_s[1];
            assign last_valid_s = valid_s[STAGES];
            assign last_sum_s   = partial_s[STAGES];
        end else begin : g_fwd
            logic [SW-1:0] fwd_sum_s;
            ops_t          held_ops_s;

            // Whole chain collapsed into one cycle, as blocking updates would give.
            always_comb begin
                fwd_sum_s = '0;
                for (int i = 0; i <= STAGES; i++) begin
                    fwd_sum_s = fwd_sum_s + {{(SW-WIDTH){1'b0}}, bus.ops_i[i]};
                end
            end

            add_chain_pipe_stage #(
                .WIDTH  (WIDTH),
                .STAGES (STAGES),
                .SW     (SW)
            ) u_stage (
                .clk          (clk),
                .rst_n        (rst_n),
                .flush_i      (flush_i),
                .up_valid_i   (in_valid_s),
                .up_partial_i (fwd_sum_s),
                .up_ops_i     (bus.ops_i),
                .add_op_i     ({WIDTH{1'b0}}),
                .down_take_i  (bus.out_ready),
                .take_o       (first_take_s),
                .valid_o      (last_valid_s),
                .partial_o    (last_sum_s),
                .ops_o        (held_ops_s)
            );
        end
    endgenerate

    assign bus.in_ready  = ~flush_i & first_take_s;
    assign bus.out_valid = last_valid_s;
    assign bus.sum_o     = last_sum_s;

    assign accept_s = in_valid_s & first_take_s;
    assign out_hs_s = last_valid_s & bus.out_ready;

    // Occupancy tracks accepts minus departures; flush empties it.
    always_comb begin
        if (flush_i) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + {{(OW-1){1'b0}}, accept_s} - {{(OW-1){1'b0}}, out_hs_s};
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule
